// File: rtl/flex_stp_word_pkg.sv
// Shared types and helpers for the flex_stp_word serial-to-parallel block.
//   out_state_t : output-side FSM state (EMPTY = no word held, FULL = word held)
//   cnt_width() : width of the bit counter for a given word width
package stp_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  // One extra bit beyond $clog2 so the counter can also represent NUM_BITS.
  function automatic int unsigned cnt_width(input int unsigned num_bits);
    return $clog2(num_bits) + 1;
  endfunction

endpackage

// File: rtl/flex_counter.sv
// Wrapping up-counter with programmable rollover value.
//   clk           : rising-edge clock
//   rst           : synchronous active-high reset, count -> 0
//   clear         : synchronous clear, count -> 0 (beats count_enable)
//   count_enable  : advance the count this cycle
//   rollover_val  : last value before wrapping back to 0
//   count_out     : current count
//   rollover_flag : count_out currently equals rollover_val
module flex_counter #(
  parameter int unsigned NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (count_enable) begin
      if (r_count == rollover_val) r_count <= '0;
      else                         r_count <= r_count + NUM_CNT_BITS'(1);
    end
  end

  // Combinational so the owner can detect "this shift completes the word".
  assign rollover_flag = (r_count == rollover_val);
  assign count_out     = r_count;

endmodule

// File: rtl/flex_stp_word.sv
// Serial-to-parallel word assembler with a one-word output holding register.
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   serial_in    : serial data bit, sampled when shift_enable=1
//   shift_enable : accept serial_in this cycle
//   clear        : abandon partial word (shift reg -> RESET_BIT fill, count -> 0)
//   word_ready   : consumer accepts word_out (ignored while word_valid=0)
//   overrun_clr  : clear the sticky overrun flag
//   partial_out  : live shift-register contents
//   bit_count    : bits accumulated in the current word
//   word_out     : last completed word
//   word_valid   : word_out holds an unconsumed word
//   overrun      : sticky, a completed word was dropped
module flex_stp_word
  import stp_pkg::*;
#(
  parameter int unsigned NUM_BITS  = 8,
  parameter bit          SHIFT_MSB = 1'b1,
  parameter logic        RESET_BIT = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          serial_in,
  input  logic                          shift_enable,
  input  logic                          clear,
  input  logic                          word_ready,
  input  logic                          overrun_clr,
  output logic [NUM_BITS-1:0]           partial_out,
  output logic [cnt_width(NUM_BITS)-1:0] bit_count,
  output logic [NUM_BITS-1:0]           word_out,
  output logic                          word_valid,
  output logic                          overrun
);

  localparam int unsigned CW = cnt_width(NUM_BITS);

  logic [NUM_BITS-1:0] r_shift;
  logic [NUM_BITS-1:0] w_next;
  logic                w_shift;
  logic                w_last_bit;
  logic                w_complete;
  logic                w_overrun_evt;
  out_state_t          r_state;
  logic [NUM_BITS-1:0] r_word_out;
  logic                r_word_valid;
  logic                r_overrun;

  assign w_shift = shift_enable && !clear;

  always_comb begin
    w_next = r_shift;
    if (SHIFT_MSB) w_next = {serial_in, r_shift[NUM_BITS-1:1]};
    else           w_next = {r_shift[NUM_BITS-2:0], serial_in};
  end

  always_ff @(posedge clk) begin
    if (rst || clear)  r_shift <= {NUM_BITS{RESET_BIT}};
    else if (w_shift)  r_shift <= w_next;
  end

  flex_counter #(
    .NUM_CNT_BITS (CW)
  ) u_counter (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .count_enable  (w_shift),
    .rollover_val  (CW'(NUM_BITS - 1)),
    .count_out     (bit_count),
    .rollover_flag (w_last_bit)
  );

  // The completed word is the post-shift value, i.e. w_next, not r_shift.
  assign w_complete    = w_shift && w_last_bit;
  assign w_overrun_evt = (r_state == FULL) && w_complete && !word_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= EMPTY;
      r_word_out   <= '0;
      r_word_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (r_state == EMPTY) begin
        if (w_complete) begin
          r_word_out   <= w_next;
          r_word_valid <= 1'b1;
          r_state      <= FULL;
        end
      end else begin
        if (w_complete) begin
          // Handshake + completion together: swap in the new word, stay FULL.
          if (word_ready) r_word_out <= w_next;
        end else if (word_ready) begin
          r_word_valid <= 1'b0;
          r_state      <= EMPTY;
        end
      end
      // A new overrun wins over a simultaneous clear request.
      if (w_overrun_evt)    r_overrun <= 1'b1;
      else if (overrun_clr) r_overrun <= 1'b0;
    end
  end

  assign partial_out = r_shift;
  assign word_out    = r_word_out;
  assign word_valid  = r_word_valid;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_flex_stp_word.sv
module tb_flex_stp_word;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       serial_in = 1'b0;
  logic       shift_enable = 1'b0;
  logic       clear = 1'b0;
  logic       word_ready = 1'b0;
  logic       overrun_clr = 1'b0;

  logic [7:0] partial_out, word_out;
  logic [3:0] bit_count;
  logic       word_valid, overrun;

  logic [7:0] l_partial_out, l_word_out;
  logic [3:0] l_bit_count;
  logic       l_word_valid, l_overrun;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  flex_stp_word #(
    .NUM_BITS  (8),
    .SHIFT_MSB (1'b1),
    .RESET_BIT (1'b1)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .shift_enable (shift_enable),
    .clear        (clear),
    .word_ready   (word_ready),
    .overrun_clr  (overrun_clr),
    .partial_out  (partial_out),
    .bit_count    (bit_count),
    .word_out     (word_out),
    .word_valid   (word_valid),
    .overrun      (overrun)
  );

  flex_stp_word #(
    .NUM_BITS  (8),
    .SHIFT_MSB (1'b0),
    .RESET_BIT (1'b1)
  ) u_dut_lsb (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .shift_enable (shift_enable),
    .clear        (clear),
    .word_ready   (word_ready),
    .overrun_clr  (overrun_clr),
    .partial_out  (l_partial_out),
    .bit_count    (l_bit_count),
    .word_out     (l_word_out),
    .word_valid   (l_word_valid),
    .overrun      (l_overrun)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; shift_enable = 1'b0; clear = 1'b0;
    word_ready = 1'b0; overrun_clr = 1'b0;
    step();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic shift_bit(input logic b);
    serial_in = b; shift_enable = 1'b1;
    step();
    shift_enable = 1'b0;
  endtask

  // MSB-entry: the first bit sent lands in bit 0, so send LSB first.
  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) shift_bit(w[i]);
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (partial_out !== 8'hFF) begin n_err++; $display("FAIL reset_partial: got %h expected ff", partial_out); end
    n_vec++; if (bit_count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", bit_count); end
    n_vec++; if (word_out !== 8'h00) begin n_err++; $display("FAIL reset_word: got %h expected 00", word_out); end
    n_vec++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", word_valid); end
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_msb_first();
    logic [7:0] w = 8'hA5;
    logic [7:0] m = 8'hFF;
    logic [7:0] e;
    do_reset();
    exp_q.push_back(w);
    for (int i = 0; i < 8; i++) begin
      shift_bit(w[i]);
      m = {w[i], m[7:1]};
      n_vec++; if (partial_out !== m) begin n_err++; $display("FAIL msb_partial[%0d]: got %h expected %h", i, partial_out, m); end
      n_vec++; if (bit_count !== 4'((i + 1) % 8)) begin n_err++; $display("FAIL msb_count[%0d]: got %0d expected %0d", i, bit_count, (i + 1) % 8); end
      n_vec++; if (word_valid !== (i == 7)) begin n_err++; $display("FAIL msb_valid[%0d]: got %b expected %b", i, word_valid, (i == 7)); end
    end
    e = exp_q.pop_front();
    n_vec++; if (word_out !== e) begin n_err++; $display("FAIL msb_word: got %h expected %h", word_out, e); end
    word_ready = 1'b1;
    step();
    word_ready = 1'b0;
    n_vec++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL msb_consume: got %b expected 0", word_valid); end
  endtask

  task automatic test_lsb_first();
    logic [7:0] bits = 8'b1100_0001;
    do_reset();
    exp_q.push_back(8'hC1);
    for (int i = 7; i >= 0; i--) shift_bit(bits[i]);
    n_vec++; if (l_word_valid !== 1'b1) begin n_err++; $display("FAIL lsb_valid: got %b expected 1", l_word_valid); end
    n_vec++; if (l_word_out !== exp_q[0]) begin n_err++; $display("FAIL lsb_word: got %h expected %h", l_word_out, exp_q[0]); end
    void'(exp_q.pop_front());
    n_vec++; if (l_bit_count !== 4'd0) begin n_err++; $display("FAIL lsb_count: got %0d expected 0", l_bit_count); end
  endtask

  task automatic test_overrun();
    logic [7:0] e;
    do_reset();
    exp_q.push_back(8'hA5);
    send_word(8'hA5);
    send_word(8'h3C);
    e = exp_q.pop_front();
    n_vec++; if (word_out !== e) begin n_err++; $display("FAIL ovr_word_kept: got %h expected %h", word_out, e); end
    n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %b expected 1", overrun); end
    n_vec++; if (word_valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid: got %b expected 1", word_valid); end
    word_ready = 1'b1;
    step();
    word_ready = 1'b0;
    n_vec++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL ovr_consume: got %b expected 0", word_valid); end
    n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
    step();
    n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_sticky2: got %b expected 1", overrun); end
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clr: got %b expected 0", overrun); end
    // Overrun event coincident with overrun_clr must leave overrun set.
    send_word(8'h0F);
    overrun_clr = 1'b1;
    send_word(8'hF0);
    overrun_clr = 1'b0;
    n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set_beats_clr: got %b expected 1", overrun); end
    n_vec++; if (word_out !== 8'h0F) begin n_err++; $display("FAIL ovr_word_kept2: got %h expected 0f", word_out); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words[2] = '{8'h11, 8'h22};
    logic [7:0] w;
    logic [7:0] e;
    int n_valid = 0;
    do_reset();
    word_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      w = words[k];
      exp_q.push_back(w);
      for (int i = 0; i < 8; i++) begin
        shift_bit(w[i]);
        if (word_valid === 1'b1) begin
          n_valid++;
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++; $display("FAIL b2b_unexpected: got %h expected none", word_out);
          end else begin
            e = exp_q.pop_front();
            if (word_out !== e) begin n_err++; $display("FAIL b2b_word: got %h expected %h", word_out, e); end
          end
        end
      end
    end
    step();
    n_vec++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b expected 0", word_valid); end
    n_vec++; if (n_valid !== 2) begin n_err++; $display("FAIL b2b_valid_cycles: got %0d expected 2", n_valid); end
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
    n_vec++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL b2b_pending: got %0d expected 0", exp_q.size()); end
    word_ready = 1'b0;

    // Handshake on the same edge as the next completion: swap, stay FULL.
    do_reset();
    send_word(8'h11);
    w = 8'h22;
    for (int i = 0; i < 7; i++) shift_bit(w[i]);
    n_vec++; if (word_out !== 8'h11) begin n_err++; $display("FAIL swap_hold: got %h expected 11", word_out); end
    word_ready = 1'b1;
    shift_bit(w[7]);
    word_ready = 1'b0;
    n_vec++; if (word_out !== 8'h22) begin n_err++; $display("FAIL swap_word: got %h expected 22", word_out); end
    n_vec++; if (word_valid !== 1'b1) begin n_err++; $display("FAIL swap_valid: got %b expected 1", word_valid); end
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL swap_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_clear();
    logic [7:0] e;
    do_reset();
    shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b0);
    n_vec++; if (bit_count !== 4'd5) begin n_err++; $display("FAIL clr_pre_count: got %0d expected 5", bit_count); end
    clear = 1'b1;
    shift_bit(1'b0);
    clear = 1'b0;
    n_vec++; if (bit_count !== 4'd0) begin n_err++; $display("FAIL clr_count: got %0d expected 0", bit_count); end
    n_vec++; if (partial_out !== 8'hFF) begin n_err++; $display("FAIL clr_partial: got %h expected ff", partial_out); end
    n_vec++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL clr_valid: got %b expected 0", word_valid); end
    exp_q.push_back(8'h5A);
    send_word(8'h5A);
    e = exp_q.pop_front();
    n_vec++; if (word_out !== e) begin n_err++; $display("FAIL clr_word: got %h expected %h", word_out, e); end
    n_vec++; if (word_valid !== 1'b1) begin n_err++; $display("FAIL clr_word_valid: got %b expected 1", word_valid); end
    // clear while FULL leaves the held word alone.
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_vec++; if (word_valid !== 1'b1 || word_out !== 8'h5A) begin n_err++; $display("FAIL clr_keeps_word: got %b/%h expected 1/5a", word_valid, word_out); end
  endtask

  task automatic test_rst_full();
    do_reset();
    send_word(8'h3C);
    send_word(8'h77);
    shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b0);
    n_vec++; if (bit_count !== 4'd3) begin n_err++; $display("FAIL rstf_pre_count: got %0d expected 3", bit_count); end
    n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL rstf_pre_overrun: got %b expected 1", overrun); end
    rst = 1'b1; shift_enable = 1'b1; serial_in = 1'b0; word_ready = 1'b1;
    step();
    rst = 1'b0; shift_enable = 1'b0; word_ready = 1'b0;
    n_vec++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL rstf_valid: got %b expected 0", word_valid); end
    n_vec++; if (word_out !== 8'h00) begin n_err++; $display("FAIL rstf_word: got %h expected 00", word_out); end
    n_vec++; if (bit_count !== 4'd0) begin n_err++; $display("FAIL rstf_count: got %0d expected 0", bit_count); end
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rstf_overrun: got %b expected 0", overrun); end
    n_vec++; if (partial_out !== 8'hFF) begin n_err++; $display("FAIL rstf_partial: got %h expected ff", partial_out); end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_overrun();
    test_back_to_back();
    test_clear();
    test_rst_full();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/flex_stp_word.md
FLEX_STP_WORD -- requirements
Module: flex_stp_word

Interface
REQ-001 SHALL provide parameter NUM_BITS, default 8, word width in bits; legal range 2..32.
REQ-002 SHALL provide parameter SHIFT_MSB, default 1; 1 = new bit enters at the MSB and shifts toward the LSB, 0 = new bit enters at the LSB and shifts toward the MSB.
REQ-003 SHALL provide parameter RESET_BIT, default 1'b1, fill value for shift-register bits after reset or clear.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-006 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have port serial_in, input, 1 bit, serial data bit.
REQ-008 SHALL have port shift_enable, input, 1 bit, sample serial_in this cycle.
REQ-009 SHALL have port clear, input, 1 bit, abandon the partial word.
REQ-010 SHALL have port word_ready, input, 1 bit, consumer accepts word_out.
REQ-011 SHALL have port overrun_clr, input, 1 bit, clear the sticky overrun flag.
REQ-012 SHALL have port partial_out, output, NUM_BITS bits, live shift-register contents.
REQ-013 SHALL have port bit_count, output, $clog2(NUM_BITS)+1 bits, bits accumulated in the current word.
REQ-014 SHALL have port word_out, output, NUM_BITS bits, last completed word.
REQ-015 SHALL have port word_valid, output, 1 bit, word_out holds an unconsumed word.
REQ-016 SHALL have port overrun, output, 1 bit, sticky flag for a lost word.

Function
REQ-017 SHALL shift the register on each rising clk when shift_enable=1 and clear=0, in the direction set by SHIFT_MSB; otherwise the register holds.
REQ-018 SHALL increment bit_count on every accepted shift and wrap it from NUM_BITS-1 to 0; counting SHALL be done by the flex_counter instance.
REQ-019 SHALL flag word completion when a shift is accepted while bit_count = NUM_BITS-1; the completed word is the post-shift register value.
REQ-020 SHALL use an output FSM with two states: EMPTY (word_valid=0) and FULL (word_valid=1).
REQ-021 EMPTY + completion SHALL load word_out and move to FULL; word_valid is asserted the cycle after the NUM_BITS-th accepted shift.
REQ-022 FULL + word_valid&word_ready with no completion SHALL move to EMPTY.
REQ-023 FULL + handshake + completion in the same cycle SHALL load the new word and stay FULL, with no overrun.
REQ-024 FULL + completion without handshake SHALL drop the new word, keep word_out, and set overrun.
REQ-025 word_out SHALL stay stable while word_valid=1 and no handshake occurs.
REQ-026 The shift register SHALL NOT be cleared on completion; partial_out keeps shifting continuously.
REQ-027 clear=1 SHALL set the shift register to all RESET_BIT and bit_count to 0, and SHALL beat a simultaneous shift_enable.
REQ-028 clear SHALL leave word_out, word_valid, the FSM state and overrun unchanged.
REQ-029 overrun SHALL stay set until overrun_clr=1; if an overrun event and overrun_clr occur in the same cycle, overrun SHALL be set.
REQ-030 word_ready SHALL be ignored while word_valid=0.

Reset
REQ-031 rst=1 at a rising clk SHALL set the shift register to all RESET_BIT, bit_count=0, word_out=0, word_valid=0 (EMPTY) and overrun=0.
REQ-032 rst SHALL override every other input, including mid-word and while FULL; the partial word and any held word are discarded.

Structure
REQ-033 Package stp_pkg SHALL hold the FSM enum out_state_t {EMPTY, FULL} and a width function for bit_count.
REQ-034 The block SHALL instantiate one sub-module, flex_counter (parameter NUM_CNT_BITS, inputs count_enable, clear, rollover_val; output count_out, rollover_flag), for bit_count.

Verification
REQ-035 NUM_BITS=8, SHIFT_MSB=1: shift bits 1,0,1,0,0,1,0,1 on consecutive cycles -> next cycle word_out=0xA5, word_valid=1, bit_count=0.
REQ-036 NUM_BITS=8, SHIFT_MSB=0: shift bits 1,1,0,0,0,0,0,1 -> word_out=0xC1.
REQ-037 Hold word_ready=0 and send two words 0xA5 then 0x3C -> word_out stays 0xA5, overrun=1; then word_ready=1 -> word_valid=0 next cycle, overrun stays 1 until overrun_clr pulses.
REQ-038 word_ready=1 continuously while streaming back-to-back words 0x11, 0x22 -> each word is presented for exactly one cycle and overrun=0.
REQ-039 Shift 5 bits, assert clear together with shift_enable -> bit_count=0, partial_out=0xFF (RESET_BIT=1); the next 8 bits form a clean word.
REQ-040 Assert rst while FULL with bit_count=3 -> next cycle word_valid=0, word_out=0x00, bit_count=0, overrun=0.
